// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage controller for a multi-cycle data memory
// Issues one-cycle strobes, waits for done or timeout, and turns HALT into a dump pulse.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] AddrIn,
    input  logic [15:0] WrDataIn,
    input  logic        MemEnableIn,
    input  logic        MemWrIn,
    input  logic        HaltIn,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWrData,
    output logic        MemRd,
    output logic        MemWr,
    input  logic        MemBusy,
    input  logic        MemDone,
    input  logic [15:0] MemRdData,
    output logic [15:0] ReadDataOut,
    output logic        Valid,
    output logic        Stall,
    output logic        Dump,
    output logic        Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_HALTED,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_rdata;
    logic             r_is_wr;
    logic             r_served;

    logic             w_take_halt;
    logic             w_misalign;
    logic             w_issue;
    logic [CNT_W-1:0] w_cnt_next;

    // A HALT that also carries a memory access is taken only on the IDLE
    // cycle right after that access completed.
    assign w_take_halt = HaltIn && (!MemEnableIn || r_served);
    assign w_misalign  = MemEnableIn && !w_take_halt && AddrIn[0];
    assign w_issue     = MemEnableIn && !w_take_halt && !AddrIn[0] && !MemBusy;
    assign w_cnt_next  = r_cnt + CNT_W'(1);

    assign MemAddr     = AddrIn;
    assign MemWrData   = WrDataIn;
    assign ReadDataOut = r_rdata;

    always_comb begin
        MemRd = 1'b0;
        MemWr = 1'b0;
        Valid = 1'b0;
        Stall = 1'b0;
        Dump  = 1'b0;
        Err   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    Stall = MemEnableIn;
                    if (w_take_halt) begin
                        Dump = 1'b1;
                    end else if (w_issue) begin
                        MemRd = !MemWrIn;
                        MemWr = MemWrIn;
                    end else if (!MemEnableIn) begin
                        Valid = 1'b1;
                    end
                end
                S_WAIT:   Stall = 1'b1;
                S_DONE:   Valid = 1'b1;
                S_HALTED: Stall = 1'b1;
                S_ERR: begin
                    Stall = 1'b1;
                    Err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_is_wr  <= 1'b0;
            r_served <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_served <= 1'b0;
                    if (w_take_halt) begin
                        r_state <= S_HALTED;
                    end else if (w_misalign) begin
                        r_state <= S_ERR;
                    end else if (w_issue) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_is_wr <= MemWrIn;
                    end
                end
                S_WAIT: begin
                    // Done wins over a timeout landing on the same edge.
                    if (MemDone) begin
                        if (!r_is_wr) begin
                            r_rdata <= MemRdData;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == TIMEOUT_C) begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_DONE: begin
                    r_served <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
// Directed test-plan steps followed by randomized accesses against a per-transaction model.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic [15:0] AddrIn;
    logic [15:0] WrDataIn;
    logic        MemEnableIn;
    logic        MemWrIn;
    logic        HaltIn;
    logic [15:0] MemAddr;
    logic [15:0] MemWrData;
    logic        MemRd;
    logic        MemWr;
    logic        MemBusy;
    logic        MemDone;
    logic [15:0] MemRdData;
    logic [15:0] ReadDataOut;
    logic        Valid;
    logic        Stall;
    logic        Dump;
    logic        Err;

    int          vectors;
    int          miscompares;
    logic [15:0] exp_rdout;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .AddrIn(AddrIn), .WrDataIn(WrDataIn),
        .MemEnableIn(MemEnableIn), .MemWrIn(MemWrIn), .HaltIn(HaltIn),
        .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemRd(MemRd), .MemWr(MemWr),
        .MemBusy(MemBusy), .MemDone(MemDone), .MemRdData(MemRdData),
        .ReadDataOut(ReadDataOut), .Valid(Valid), .Stall(Stall),
        .Dump(Dump), .Err(Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with rst low.
    task automatic apply_reset();
        rst = 1'b1;
        MemEnableIn = 1'b0;
        HaltIn = 1'b0;
        MemBusy = 1'b0;
        MemDone = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_strobes", 32'({MemRd, MemWr}), 32'd0);
        chk("rst_flags", 32'({Valid, Stall, Dump, Err}), 32'd0);
        chk("rst_rdout", 32'(ReadDataOut), 32'd0);
        exp_rdout = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One access with a memory responder: busy for busy_n cycles, done on the
    // lat-th cycle after the strobe (lat = 0 never answers).
    task automatic run_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rdata, input int busy_n, input int lat,
                              input logic halt);
        int   rd_n, wr_n, st_n, busy_strobe, since;
        logic req, got_valid, got_err, fin, strobe;
        int   e_rd, e_wr, e_stall;
        logic e_err, e_valid;
        rd_n = 0; wr_n = 0; st_n = 0; busy_strobe = 0; since = 0;
        req = 1'b0; got_valid = 1'b0; got_err = 1'b0; fin = 1'b0;
        if (addr[0]) begin
            e_rd = 0; e_wr = 0; e_stall = 2; e_err = 1'b1; e_valid = 1'b0;
        end else if (lat >= 1 && lat <= TIMEOUT) begin
            e_rd = wr ? 0 : 1; e_wr = wr ? 1 : 0;
            e_stall = busy_n + 1 + lat; e_err = 1'b0; e_valid = 1'b1;
            if (!wr) exp_rdout = rdata;
        end else begin
            e_rd = wr ? 0 : 1; e_wr = wr ? 1 : 0;
            e_stall = busy_n + 1 + TIMEOUT + 1; e_err = 1'b1; e_valid = 1'b0;
        end
        MemEnableIn = 1'b1; MemWrIn = wr; AddrIn = addr; WrDataIn = wdata; HaltIn = halt;
        for (int c = 0; c < 60 && !fin; c++) begin
            MemBusy = (c < busy_n);
            MemDone = req && (since == lat);
            MemRdData = MemDone ? rdata : 16'($urandom);
            @(negedge clk);
            if (Stall) st_n++;
            if (MemRd) rd_n++;
            if (MemWr) wr_n++;
            strobe = MemRd || MemWr;
            if (strobe && MemBusy) busy_strobe++;
            if (strobe) begin
                chk("addr_pass", 32'(MemAddr), 32'(addr));
                chk("wdata_pass", 32'(MemWrData), 32'(wdata));
            end
            if (Valid) begin
                got_valid = 1'b1;
                fin = 1'b1;
                chk("done_rdout", 32'(ReadDataOut), 32'(exp_rdout));
            end
            if (Err) begin
                got_err = 1'b1;
                fin = 1'b1;
            end
            @(posedge clk); #1;
            if (req) since++;
            if (strobe) begin
                req = 1'b1;
                since = 1;
            end
        end
        MemBusy = 1'b0;
        MemDone = 1'b0;
        chk("access_finished", 32'(fin), 32'd1);
        chk("valid_seen", 32'(got_valid), 32'(e_valid));
        chk("err_seen", 32'(got_err), 32'(e_err));
        chk("rd_pulses", 32'(rd_n), 32'(e_rd));
        chk("wr_pulses", 32'(wr_n), 32'(e_wr));
        chk("stall_cycles", 32'(st_n), 32'(e_stall));
        chk("strobe_while_busy", 32'(busy_strobe), 32'd0);
    endtask

    task automatic idle_cycle();
        MemEnableIn = 1'b0;
        HaltIn = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(Valid), 32'd1);
        chk("idle_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [15:0] ra, rd_d, rr;
    logic        rw;
    int          rb, rl;

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_rdout = 16'h0000;
        rst = 1'b1;
        AddrIn = 16'h0; WrDataIn = 16'h0; MemEnableIn = 1'b0; MemWrIn = 1'b0;
        HaltIn = 1'b0; MemBusy = 1'b0; MemDone = 1'b0; MemRdData = 16'h0;

        apply_reset();
        idle_cycle();

        run_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 3, 1'b0);
        idle_cycle();
        chk("load_beef", 32'(ReadDataOut), 32'h0000BEEF);

        run_access(1'b1, 16'h0020, 16'h1234, 16'h5555, 2, 2, 1'b0);
        idle_cycle();
        chk("store_keeps_rdout", 32'(ReadDataOut), 32'h0000BEEF);

        run_access(1'b0, 16'h0011, 16'h0000, 16'h1111, 0, 2, 1'b0);
        apply_reset();

        run_access(1'b0, 16'h0040, 16'h0000, 16'h2222, 0, 0, 1'b0);
        MemEnableIn = 1'b1;
        AddrIn = 16'h0042;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_sticky", 32'({Err, Stall, MemRd, MemWr}), 32'b1100);
            @(posedge clk); #1;
        end
        apply_reset();

        run_access(1'b0, 16'h0044, 16'h0000, 16'h3333, 1, TIMEOUT, 1'b0);
        idle_cycle();
        chk("done_at_timeout_rdout", 32'(ReadDataOut), 32'h00003333);

        // Load carrying HALT: access first, then the dump on the following IDLE cycle.
        run_access(1'b0, 16'h0050, 16'h0000, 16'h4444, 0, 2, 1'b1);
        @(negedge clk);
        chk("halt_after_access_dump", 32'({Dump, MemRd, MemWr}), 32'b100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("halt_after_access_parked", 32'({Stall, Dump}), 32'b10);
        @(posedge clk); #1;
        apply_reset();

        MemEnableIn = 1'b0;
        HaltIn = 1'b1;
        @(negedge clk);
        chk("halt_dump", 32'({Dump, Valid, Stall}), 32'b100);
        @(posedge clk); #1;
        HaltIn = 1'b0;
        MemEnableIn = 1'b1;
        MemWrIn = 1'b0;
        AddrIn = 16'h0060;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halted", 32'({Stall, Dump, MemRd, MemWr, Valid, Err}), 32'b100000);
            @(posedge clk); #1;
        end
        apply_reset();
        idle_cycle();

        // Reset landing mid-access, then a late response.
        exp_rdout = 16'h0000;
        MemEnableIn = 1'b1; MemWrIn = 1'b0; AddrIn = 16'h0070; MemBusy = 1'b0; MemDone = 1'b0;
        @(negedge clk);
        chk("rw_request", 32'(MemRd), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        MemEnableIn = 1'b0;
        MemDone = 1'b1;
        MemRdData = 16'hDEAD;
        @(negedge clk);
        chk("rw_valid_in_rst", 32'(Valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rw_late_done_ignored", 32'({Stall, MemRd, MemWr, Err}), 32'd0);
        chk("rw_rdout_cleared", 32'(ReadDataOut), 32'd0);
        @(posedge clk); #1;
        MemDone = 1'b0;
        @(negedge clk);
        chk("rw_rdout_still_zero", 32'(ReadDataOut), 32'd0);
        @(posedge clk); #1;

        for (int t = 0; t < 30; t++) begin
            rw = 1'($urandom);
            ra = 16'($urandom);
            if ($urandom_range(7) != 0) ra[0] = 1'b0;
            rd_d = 16'($urandom);
            rr = 16'($urandom);
            rb = $urandom_range(3);
            rl = ($urandom_range(5) == 0) ? 0 : $urandom_range(TIMEOUT, 1);
            run_access(rw, ra, rd_d, rr, rb, rl, 1'b0);
            if (ra[0] || rl == 0) begin
                apply_reset();
            end else begin
                idle_cycle();
                chk("rand_rdout", 32'(ReadDataOut), 32'(exp_rdout));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
